imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into the instruction memory through a synchronous write port. It sits between the host/serial front end and the instruction memory, and holds the CPU in reset until a complete image has landed.

## Interface

- ADDR_WIDTH, 10, word-address width of the instruction memory; capacity is 2**ADDR_WIDTH words.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- BYTE_IN  input  8  incoming stream byte.
- BYTE_VALID  input  1  BYTE_IN is valid this cycle.
- BYTE_READY  output  1  loader accepts BYTE_IN this cycle.
- LOAD_REQ  input  1  single-cycle pulse that restarts loading from DONE or ERROR.
- IMEM_ADDR  output  ADDR_WIDTH  word address for the write.
- IMEM_WRITE_DATA  output  32  instruction word.
- IMEM_WRITE_ENABLE  output  1  one-cycle write strobe.
- CPU_HOLD  output  1  high while the CPU must remain in reset.
- DONE  output  1  image loaded successfully; stays high until LOAD_REQ or reset.
- ERROR  output  1  load aborted; stays high until LOAD_REQ or reset.

## Operation

- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N payload bytes, each word little-endian (first byte goes to [7:0]). With checksum enabled, one checksum byte follows.
- A byte transfers on a rising edge where BYTE_VALID && BYTE_READY. BYTE_VALID without BYTE_READY is ignored; the sender holds the byte.
- States:
  - S_LEN0: capture LEN_LO.
  - S_LEN1: capture LEN_HI. If N == 0, go to S_CSUM when checksum is enabled, else S_DONE. If N > 2**ADDR_WIDTH, go to S_ERROR. Otherwise go to S_DATA.
  - S_DATA: shift in bytes with a 2-bit byte counter. On the 4th byte, go to S_WRITE.
  - S_WRITE: assert IMEM_WRITE_ENABLE for one cycle at the current word address, then increment the address and the word counter. If the word count reaches N, go to S_CSUM or S_DONE; otherwise return to S_DATA.
  - S_CSUM: compare the byte with the running value. Match goes to S_DONE; mismatch goes to S_ERROR.
  - S_DONE: DONE=1, CPU_HOLD=0.
  - S_ERROR: ERROR=1, CPU_HOLD=1.
- BYTE_READY is 1 in S_LEN0, S_LEN1, S_DATA and S_CSUM, and 0 in S_WRITE, S_DONE and S_ERROR.
- LOAD_REQ is honoured only in S_DONE or S_ERROR. It clears DONE, ERROR, the address, the counters and the checksum, sets CPU_HOLD=1, and enters S_LEN0. LOAD_REQ in any other state is ignored.
- Address arithmetic is ADDR_WIDTH bits. N == 2**ADDR_WIDTH is legal: the address wraps to 0 after the last write, and that wrap is not an error.
- The word counter is 17 bits wide so that N up to 65535 can be compared without overflow.

## Timing

- Reset values: state S_LEN0, BYTE_READY=0 while RST_N is low (1 from the first edge after release), IMEM_ADDR=0, IMEM_WRITE_DATA=0, IMEM_WRITE_ENABLE=0, CPU_HOLD=1, DONE=0, ERROR=0.
- Reset asserted mid-frame aborts immediately. No partial write is issued. The next frame starts at LEN_LO.
- IMEM_WRITE_DATA and IMEM_ADDR are registered and stable during the IMEM_WRITE_ENABLE cycle. The write occurs on the edge that ends S_WRITE.
- Latency:
  - 4th payload byte accepted on edge k: write strobe high during cycle k+1.
  - Earliest next byte: edge k+2.
  - Sustained rate: 5 cycles per word.
- DONE rises and CPU_HOLD falls on the edge after the last write (no checksum) or after the checksum byte is accepted.

## Configuration

- IMEM_LOADER_CHECKSUM_EN defined: a running XOR of all payload bytes (length bytes excluded, initial value 8'h00) is kept, S_CSUM exists, and a mismatch sets ERROR.
- Undefined: no checksum register and no S_CSUM state. The frame ends with the last payload byte.

## Structure

- Shared package imem_loader_pkg holds:
  - the state enum (S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR);
  - the word width constant, 32;
  - the bytes-per-word constant, 4.
- One sub-module, imem_word_packer: byte shift register plus 2-bit counter, with a word_ready pulse. All other logic stays in the top-level FSM.

## Test plan

- Reset, then stream 02 00 13 00 00 00 93 00 10 00: writes 0x00000013 to address 0 and 0x00100093 to address 1, then DONE=1 and CPU_HOLD=0.
- Same frame with BYTE_VALID toggling every other cycle, and with BYTE_VALID held high through S_WRITE: identical writes, no byte lost or duplicated, BYTE_READY=0 during each strobe cycle.
- Length 01 08 (N=2049 > 1024): ERROR=1, CPU_HOLD=1, no IMEM_WRITE_ENABLE ever asserted.
- With the checksum macro, frame 01 00 13 00 00 00 13 goes to DONE. The same frame with checksum 12 goes to ERROR. A LOAD_REQ pulse then returns to S_LEN0 with ERROR=0 and IMEM_ADDR=0.
- RST_N pulsed low after 2 of 4 payload bytes: all outputs return to reset values and no write occurs. A fresh frame then loads from address 0.
- N=0 (00 00, checksum 00 when enabled): DONE=1 with zero writes.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_WIDTH     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in plus instruction-memory write port out; master is the loader side.
interface imem_loader_if #(parameter int ADDR_WIDTH = 10);
  import imem_loader_pkg::*;

  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [WORD_WIDTH-1:0] imem_write_data;
  logic                  imem_write_enable;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, imem_addr, imem_write_data, imem_write_enable
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, imem_addr, imem_write_data, imem_write_enable
  );

endinterface

// File: rtl/imem_word_packer.sv
// Shifts accepted bytes into a little-endian word; word_ready pulses with the last byte of a word.
// Latency: word_dat holds the full word from the edge that accepts the last byte; no backpressure of its own.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  byte_vld,
  input  logic [7:0]            byte_dat,
  output logic [WORD_WIDTH-1:0] word_dat,
  output logic                  word_ready
);

  localparam logic [BCNT_WIDTH-1:0] LAST_BYTE = BCNT_WIDTH'(BYTES_PER_WORD - 1);

  logic [BCNT_WIDTH-1:0] cnt;

  // New bytes enter at the top so the first byte ends up in [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      word_dat <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (byte_vld) begin
      cnt      <= cnt + BCNT_WIDTH'(1);
      word_dat <= {byte_dat, word_dat[WORD_WIDTH-1:8]};
    end
  end

  assign word_ready = byte_vld && (cnt == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte frame -> sequential 32-bit imem writes; write strobe one cycle after 4th byte, 5 cycles/word.
// byte_ready drops during the write cycle and after DONE/ERROR; optional trailing XOR checksum with IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.master bus,
  input  logic         load_req,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = S_CSUM;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  state_t                state, state_nxt;
  logic                  rdy_en;
  logic [7:0]            len_lo;
  logic [15:0]           len;
  logic [16:0]           word_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [16:0]           len_n;
  logic                  byte_fire, data_fire, clr, last_word, word_ready;
  logic [WORD_WIDTH-1:0] word_dat;

  assign byte_fire = bus.byte_valid && bus.byte_ready;
  assign data_fire = byte_fire && (state == S_DATA);
  assign clr       = load_req && ((state == S_DONE) || (state == S_ERROR));
  assign len_n     = {1'b0, bus.byte_in, len_lo};
  assign last_word = (word_cnt + 17'd1) == {1'b0, len};

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .byte_vld   (data_fire),
    .byte_dat   (bus.byte_in),
    .word_dat   (word_dat),
    .word_ready (word_ready)
  );

  assign bus.imem_write_data = word_dat;
  assign bus.imem_addr       = addr;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         csum <= 8'h00;
    else if (clr)       csum <= 8'h00;
    else if (data_fire) csum <= csum ^ bus.byte_in;
  end
`endif

  // Keeps byte_ready low while reset is held, even though state already reads S_LEN0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LEN0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN0:  if (byte_fire) state_nxt = S_LEN1;
      S_LEN1: begin
        if (byte_fire) begin
          if (len_n == 17'd0)       state_nxt = END_STATE;
          else if (len_n > CAPACITY) state_nxt = S_ERROR;
          else                       state_nxt = S_DATA;
        end
      end
      S_DATA:  if (word_ready) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_word ? END_STATE : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (byte_fire) state_nxt = (bus.byte_in == csum) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE, S_ERROR: if (load_req) state_nxt = S_LEN0;
      default: state_nxt = S_LEN0;
    endcase
  end

  always_comb begin
    bus.byte_ready        = 1'b0;
    bus.imem_write_enable = 1'b0;
    cpu_hold              = 1'b1;
    done                  = 1'b0;
    error                 = 1'b0;
    case (state)
      S_LEN0, S_LEN1, S_DATA, S_CSUM: bus.byte_ready = rdy_en;
      S_WRITE: bus.imem_write_enable = 1'b1;
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  // Address wraps naturally at ADDR_WIDTH bits; a full-capacity image lands back on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo   <= 8'h00;
      len      <= 16'h0000;
      word_cnt <= 17'd0;
      addr     <= '0;
    end else if (clr) begin
      word_cnt <= 17'd0;
      addr     <= '0;
    end else begin
      if ((state == S_LEN0) && byte_fire) len_lo <= bus.byte_in;
      if ((state == S_LEN1) && byte_fire) len    <= {bus.byte_in, len_lo};
      if (state == S_WRITE) begin
        addr     <= addr + ADDR_WIDTH'(1);
        word_cnt <= word_cnt + 17'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame bench for imem_loader with a queue-based reference model of the frame format.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int AW  = 10;
  localparam int CAP = 1 << AW;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_req = 1'b0;
  logic cpu_hold, done, error;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .load_req (load_req),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed writes and strobe-cycle ready violations.
  logic [AW+31:0] wq[$];
  int rdy_viol = 0;

  always @(negedge clk) begin
    if (bus.imem_write_enable === 1'b1) begin
      wq.push_back({bus.imem_addr, bus.imem_write_data});
      if (bus.byte_ready !== 1'b0) rdy_viol++;
    end
  end

  // Reference model: derives expected writes and outcome straight from the frame bytes.
  logic [7:0]     fr[$];
  logic [AW+31:0] exp_q[$];
  bit             exp_ok;
  int             exp_addr;

  task automatic model();
    int n;
    logic [7:0] x;
    logic [31:0] w;
    n = int'(fr[0]) + 256 * int'(fr[1]);
    exp_q.delete();
    x = 8'h00;
    if (n > CAP) begin
      exp_ok = 1'b0;
      exp_addr = 0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {fr[2+4*i+3], fr[2+4*i+2], fr[2+4*i+1], fr[2+4*i]};
      x = x ^ fr[2+4*i] ^ fr[2+4*i+1] ^ fr[2+4*i+2] ^ fr[2+4*i+3];
      exp_q.push_back({AW'(i % CAP), w});
    end
    exp_ok   = CSUM ? (fr[2+4*n] == x) : 1'b1;
    exp_addr = n % CAP;
  endtask

  task automatic append_csum(input bit bad);
    logic [7:0] x;
    if (CSUM) begin
      x = 8'h00;
      for (int i = 2; i < fr.size(); i++) x = x ^ fr[i];
      fr.push_back(bad ? (x ^ 8'h01) : x);
    end
  endtask

  task automatic build_frame(input int n, input bit bad);
    fr.delete();
    fr.push_back(n[7:0]);
    fr.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) fr.push_back(8'($urandom_range(0, 255)));
    append_csum(bad);
  endtask

  // mode 0: valid always high; 1: valid every other cycle; 2: random valid.
  task automatic send(input int mode, input int nbytes);
    int idx = 0;
    int cyc = 0;
    bit v;
    while (idx < nbytes) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.byte_valid = v;
      bus.byte_in    = fr[idx];
      if (v && (bus.byte_ready === 1'b1)) idx++;
      cyc++;
      if (cyc > 60 * nbytes + 100) begin
        chk("send_timeout", idx, nbytes);
        break;
      end
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic run_frame(input int mode, input string tag);
    int t = 0;
    int nw;
    model();
    wq.delete();
    rdy_viol = 0;
    send(mode, fr.size());
    while (!((done === 1'b1) || (error === 1'b1)) && (t < 40)) begin
      @(negedge clk);
      t++;
    end
    nw = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
    chk({tag, "_nwrites"}, wq.size(), exp_q.size());
    for (int i = 0; i < nw; i++) chk($sformatf("%s_wr%0d", tag, i), wq[i], exp_q[i]);
    chk({tag, "_done"},     done,     exp_ok);
    chk({tag, "_error"},    error,    !exp_ok);
    chk({tag, "_cpu_hold"}, cpu_hold, !exp_ok);
    chk({tag, "_addr"},     bus.imem_addr, exp_addr);
    chk({tag, "_rdy_in_strobe"}, rdy_viol, 0);
  endtask

  task automatic restart(input string tag);
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk({tag, "_rst_done"},  done,           1'b0);
    chk({tag, "_rst_error"}, error,          1'b0);
    chk({tag, "_rst_addr"},  bus.imem_addr,  0);
    chk({tag, "_rst_hold"},  cpu_hold,       1'b1);
    chk({tag, "_rst_ready"}, bus.byte_ready, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.byte_ready,        1'b0);
    chk({tag, "_addr"},  bus.imem_addr,         0);
    chk({tag, "_wdata"}, bus.imem_write_data,   0);
    chk({tag, "_we"},    bus.imem_write_enable, 1'b0);
    chk({tag, "_hold"},  cpu_hold,              1'b1);
    chk({tag, "_done"},  done,                  1'b0);
    chk({tag, "_error"}, error,                 1'b0);
  endtask

  task automatic basic_frame();
    fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    append_csum(1'b0);
  endtask

  initial begin
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", bus.byte_ready, 1'b1);

    basic_frame();
    run_frame(0, "basic");
    restart("r1");
    basic_frame();
    run_frame(1, "toggle");
    restart("r2");
    basic_frame();
    run_frame(2, "randvld");

    restart("r3");
    fr = '{8'h01, 8'h08};
    run_frame(0, "oversize");

`ifdef IMEM_LOADER_CHECKSUM_EN
    restart("r4");
    fr = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run_frame(0, "csum_ok");
    restart("r5");
    fr = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    run_frame(0, "csum_bad");
`endif

    restart("r6");
    fr = '{8'h01, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd};
    wq.delete();
    send(0, 4);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_write", wq.size(), 0);
    basic_frame();
    run_frame(0, "after_rst");

    restart("r7");
    fr = '{8'h00, 8'h00};
    append_csum(1'b0);
    run_frame(0, "n0");

    for (int k = 0; k < 6; k++) begin
      restart($sformatf("rr%0d", k));
      build_frame($urandom_range(1, 8), CSUM && ($urandom_range(0, 3) == 0));
      run_frame($urandom_range(0, 2), $sformatf("rand%0d", k));
    end

    restart("r8");
    build_frame(CAP, 1'b0);
    run_frame(0, "full");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
